// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types, constants and helpers for the shared-channel
//                arbiters (round-robin grant FSM and priority picker).
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int DEFAULT_MASTERS = 2;

    // Upper bound on requesters supported by onehot(); the index width matches.
    localparam int MAX_MASTERS = 32;
    localparam int IDX_W       = 5;

    // One-hot decode of a binary master index.
    function automatic logic [MAX_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority picker. Returns the first set
//                request found searching upward from ptr with wrap-around.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int MASTERS = 2,
    parameter int ID_W    = 1
) (
    input  logic [MASTERS-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            w_cand = ID_W'((int'(ptr) + i) % MASTERS);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rr_arbiter
//  Description : Round-robin transaction arbiter for one shared AXI channel
//                group. Holds a one-hot grant from address handshake through
//                the final data/response beat, then rotates priority.
//                Optional watchdog: define ARB_WATCHDOG_EN to force release of
//                a grant held for TIMEOUT cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int MASTERS = DEFAULT_MASTERS,
    parameter  int TIMEOUT = 255,
    localparam int ID_W    = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASTERS-1:0] req,
    input  logic               addr_ready,
    input  logic               done,
    output logic [MASTERS-1:0] sel,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout
);

    localparam logic [ID_W-1:0] c_last_id = ID_W'(MASTERS - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [MASTERS-1:0] r_sel;
    logic [MASTERS-1:0] w_sel_nxt;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    w_grant_id_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_release;
    logic               w_found;
    logic [ID_W-1:0]    w_pick_idx;
    logic [MASTERS-1:0] w_pick_oh;

    rr_pick #(
        .MASTERS (MASTERS),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_pick_oh = MASTERS'(onehot(IDX_W'(w_pick_idx)));

`ifdef ARB_WATCHDOG_EN
    localparam int              c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
`endif

    // Next-state and next-grant decode; defaults hold the current grant.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_release      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ADDR;
                    w_sel_nxt      = w_pick_oh;
                    w_grant_id_nxt = w_pick_idx;
                end else begin
                    w_sel_nxt      = '0;
                    w_grant_id_nxt = '0;
                end
            end
            // A withdrawn VALID is not a release: keep waiting for the handshake.
            ADDR: begin
                if (req[r_grant_id] && addr_ready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (done) begin
                    w_release = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
        endcase

`ifdef ARB_WATCHDOG_EN
        // Counter sits at zero in IDLE so it starts fresh on entry to ADDR.
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        if (r_state == IDLE) begin
            w_cnt_nxt = '0;
        end else if (!w_release) begin
            if (r_cnt == c_cnt_last) begin
                w_release     = 1'b1;
                w_timeout_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
`endif

        // Release drops the grant and hands top priority to the next master.
        if (w_release) begin
            w_state_nxt    = IDLE;
            w_sel_nxt      = '0;
            w_grant_id_nxt = '0;
            w_ptr_nxt      = (r_grant_id == c_last_id) ? '0 : r_grant_id + 1'b1;
        end
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

`ifdef ARB_WATCHDOG_EN
    // Watchdog counter and one-cycle release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign sel      = r_sel;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == ADDR) || (r_state == DATA);

    // The mux downstream relies on never seeing two selects at once.
    a_sel_onehot0 : assert property (@(posedge clk) $onehot0(r_sel));

    // Parameter sanity: picker decode range and a non-zero watchdog limit.
    a_param_range : assert property (@(posedge clk)
        (MASTERS >= 1) && (MASTERS <= MAX_MASTERS) && (TIMEOUT >= 1));

endmodule
`default_nettype wire

// File: tb/tb_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rr_arbiter
//  Description : Directed self-checking bench for axi_rr_arbiter (2 masters).
//                Watchdog checks follow ARB_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       addr_ready;
    logic       done;
    logic [1:0] sel;
    logic [0:0] grant_id;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_err;

    axi_rr_arbiter #(
        .MASTERS (2),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr_ready (addr_ready),
        .done       (done),
        .sel        (sel),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] e_sel,
                             input logic e_gid, input logic e_busy);
        check({tag, ".sel"},  32'(sel),      32'(e_sel));
        check({tag, ".gid"},  32'(grant_id), 32'(e_gid));
        check({tag, ".busy"}, 32'(busy),     32'(e_busy));
    endtask

    // One complete transaction from IDLE with req already driven.
    task automatic do_txn(input string tag, input logic [1:0] e_sel, input logic e_gid);
        tick();
        chk_grant({tag, ".grant"}, e_sel, e_gid, 1'b1);
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
        chk_grant({tag, ".data"}, e_sel, e_gid, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_grant({tag, ".idle"}, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        req        = 2'b00;
        addr_ready = 1'b0;
        done       = 1'b0;

        // Reset held three cycles, then idle with no requests.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_grant("reset", 2'b00, 1'b0, 1'b0);
            check("reset.timeout", 32'(timeout), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk_grant("idle", 2'b00, 1'b0, 1'b0);

        // Single master 1: grant next cycle, held through ADDR and DATA.
        req = 2'b10;
        tick();
        chk_grant("single.grant", 2'b10, 1'b1, 1'b1);
        tick();
        chk_grant("single.addr_wait", 2'b10, 1'b1, 1'b1);
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
        req        = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_grant("single.data", 2'b10, 1'b1, 1'b1);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_grant("single.release", 2'b00, 1'b0, 1'b0);

        // Fairness: ptr wrapped to 0, so alternation starts with master 0.
        req = 2'b11;
        do_txn("rr1", 2'b01, 1'b0);
        do_txn("rr2", 2'b10, 1'b1);
        do_txn("rr3", 2'b01, 1'b0);
        do_txn("rr4", 2'b10, 1'b1);

        // Stability: req changes and stray done must not move the grant.
        req = 2'b01;
        tick();
        chk_grant("stab.grant", 2'b01, 1'b0, 1'b1);
        req = 2'b10;
        tick();
        chk_grant("stab.toggle", 2'b01, 1'b0, 1'b1);
        req = 2'b00;
        tick();
        chk_grant("stab.drop", 2'b01, 1'b0, 1'b1);
        req        = 2'b10;
        addr_ready = 1'b1;
        tick();
        chk_grant("stab.no_hs", 2'b01, 1'b0, 1'b1);
        addr_ready = 1'b0;
        done       = 1'b1;
        tick();
        chk_grant("stab.done_in_addr", 2'b01, 1'b0, 1'b1);
        done       = 1'b0;
        req        = 2'b01;
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
        req        = 2'b10;
        tick();
        chk_grant("stab.data", 2'b01, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_grant("stab.release", 2'b00, 1'b0, 1'b0);

        // Reset mid-DATA on master 1; ptr must return to 0 afterwards.
        req = 2'b10;
        tick();
        chk_grant("rstmid.grant", 2'b10, 1'b1, 1'b1);
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        chk_grant("rstmid.cleared", 2'b00, 1'b0, 1'b0);
        req = 2'b11;
        do_txn("rstmid.after", 2'b01, 1'b0);

        // Long grant on master 1 with no done.
        tick();
        chk_grant("hold.grant", 2'b10, 1'b1, 1'b1);
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
`ifdef ARB_WATCHDOG_EN
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_grant("wd.hold", 2'b10, 1'b1, 1'b1);
            check("wd.no_pulse", 32'(timeout), 32'd0);
        end
        tick();
        chk_grant("wd.release", 2'b00, 1'b0, 1'b0);
        check("wd.pulse", 32'(timeout), 32'd1);
        tick();
        chk_grant("wd.next", 2'b01, 1'b0, 1'b1);
        check("wd.pulse_end", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            check("hold.sel", 32'(sel), 32'd2);
            check("hold.timeout", 32'(timeout), 32'd0);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_grant("hold.release", 2'b00, 1'b0, 1'b0);
        tick();
        chk_grant("hold.next", 2'b01, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- Round-robin arbiter that produces the one-hot `sel` vector consumed by the interconnect's one-hot channel Mux.
- Grants one AXI master at a time for a full transaction: address handshake, then data phase up to the last beat. The grant is held stable for the whole transaction.
- One instance sits in front of each shared slave-side channel group (read path or write path).

Parameters:
- MASTERS, 2, number of requesting masters; width of req/sel.
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  MASTERS  per-master address VALID (ARVALID or AWVALID)
- addr_ready  in  1  address READY from the granted path
- done  in  1  transaction-complete strobe (e.g. RVALID&RREADY&RLAST, or BVALID&BREADY)
- sel  out  MASTERS  one-hot grant; all-zero when idle; feeds the Mux sel
- grant_id  out  $clog2(MASTERS) (min 1)  binary index of granted master; 0 when idle
- busy  out  1  high in ADDR or DATA
- timeout  out  1  one-cycle pulse on watchdog release; constant 0 without the macro

Behaviour:
- Reset:
  - state=IDLE, sel=0, grant_id=0, busy=0, timeout=0.
  - Priority pointer ptr=0, so master 0 has highest priority first.
- States:
  - IDLE:
    - If |req, pick the first set req[i] searching from ptr upward with wrap-around.
    - Register sel=onehot(i) and grant_id=i; next state ADDR.
    - If no req, stay in IDLE with sel=0.
    - Latency: req at cycle N gives sel valid at N+1.
  - ADDR:
    - sel held.
    - If req[grant_id] & addr_ready, next state DATA.
    - A dropped req is not a release; the arbiter keeps waiting (AXI forbids VALID withdrawal).
  - DATA:
    - sel held.
    - On done: next state IDLE, sel=0, ptr=(grant_id+1) mod MASTERS.
    - The newly freed master therefore has lowest priority next round.
- done is sampled only in DATA. done in IDLE or ADDR is ignored.
- There is one idle cycle between transactions; back-to-back grants are not supported.
- sel is always one-hot or zero. An assertion checks $onehot0(sel) every cycle.
- Changes in req are never allowed to alter sel outside IDLE.
- ptr wrap: MASTERS-1 -> 0. MASTERS=1 is legal: ptr stays 0.
- rst asserted in ADDR or DATA: return to IDLE next edge. sel=0 and ptr=0; the in-flight grant is dropped.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- When defined:
  - A cycle counter clears on entry to ADDR and increments each cycle in ADDR or DATA.
  - When it reaches TIMEOUT, force IDLE: sel=0, ptr advanced as if done, timeout=1 for one cycle.
  - Counter width is $clog2(TIMEOUT+1).
- When undefined: no counter, timeout tied 0, and a grant is held indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e
  - localparam DEFAULT_MASTERS=2
  - function onehot(idx)
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req, ptr.
  - Outputs: found, idx.
  - Reused by any other shared-channel arbiter.

Test Plan:
- Reset then idle: rst held 3 cycles, req=0 -> sel=0, busy=0, grant_id=0 on every cycle.
- Single master:
  - req=2'b10 at cycle 5 -> sel=2'b10 at cycle 6.
  - addr_ready at cycle 8 -> DATA.
  - done at cycle 12 -> sel=0 at cycle 13, ptr=0.
- Round-robin fairness, both req held high:
  - Grants alternate 01,10,01,10 over 4 transactions.
  - Exactly one idle cycle between them.
- Stability: grant to master 0, req[1] toggles and req[0] drops in ADDR -> sel stays 2'b01 until addr_ready then done.
- Reset mid-DATA: rst pulsed while granted to master 1 -> sel=0 next cycle. With both req high afterwards, master 0 is granted first.
- Watchdog (ARB_WATCHDOG_EN, TIMEOUT=8):
  - Grant with no done -> timeout pulses after 8 cycles in ADDR/DATA, sel=0, other master granted next.
  - Without the macro: sel held at least 100 cycles and timeout stays 0.
